// File: rtl/arith_pkg.sv
// arith_pkg: shared subtractor constants and the 4-bit borrow-lookahead combine
package arith_pkg;
  localparam int LA_BLOCK = 4;
  // Returns the borrows into bits 1..3 of the block and the block borrow-out, msb first.
  function automatic logic [LA_BLOCK-1:0] borrow_lookahead4(
    input logic [LA_BLOCK-1:0] g,
    input logic [LA_BLOCK-1:0] p,
    input logic bin
  );
    return {g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0] | (&p) & bin,
            g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & bin,
            g[1] | p[1] & g[0] | p[1] & p[0] & bin,
            g[0] | p[0] & bin};
  endfunction
endpackage

// File: rtl/full_subtractor_bit.sv
// full_subtractor_bit: one-bit combinational full subtractor cell
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

// File: rtl/full_subtractor.sv
// full_subtractor: registered diff = a - b - cin with borrow-out, ripple or 4-bit lookahead
module full_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int LOOKAHEAD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  logic [WIDTH-1:0] d;
  logic bo;
  genvar i, k;
  generate
    if (LOOKAHEAD == 0) begin : g_ripple
      logic [WIDTH:0] bc;
      assign bc[0] = cin;
      for (i = 0; i < WIDTH; i++) begin : g_bit
        full_subtractor_bit u_bit (.a(a[i]), .b(b[i]), .bin(bc[i]), .d(d[i]), .bout(bc[i+1]));
      end
      assign bo = bc[WIDTH];
    end else begin : g_la
      localparam int NB = (WIDTH + LA_BLOCK - 1) / LA_BLOCK;
      localparam int PW = NB * LA_BLOCK;
      logic [PW-1:0] g, p;
      logic [PW:0] c;
      assign c[0] = cin;
      // With bin tied low the cell yields g on bout and a^b on d, i.e. ~p.
      for (i = 0; i < PW; i++) begin : g_bit
        if (i < WIDTH) begin : g_cell
          logic x;
          full_subtractor_bit u_bit (.a(a[i]), .b(b[i]), .bin(1'b0), .d(x), .bout(g[i]));
          assign p[i] = ~x;
          assign d[i] = x ^ c[i];
        end else begin : g_pad
          assign g[i] = 1'b0;
          assign p[i] = 1'b1;
        end
      end
      for (k = 0; k < NB; k++) begin : g_blk
        assign c[LA_BLOCK*k+1 +: LA_BLOCK] =
          borrow_lookahead4(g[LA_BLOCK*k +: LA_BLOCK], p[LA_BLOCK*k +: LA_BLOCK], c[LA_BLOCK*k]);
      end
      // Pad bits only propagate, so every borrow from bit WIDTH upward is the same value.
      assign bo = &c[PW:WIDTH];
    end
  endgenerate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      diff <= '0;
      borrow <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff <= d;
        borrow <= bo;
      end
    end
  end
endmodule

// File: tb/tb_full_subtractor.sv
// tb_full_subtractor: table vectors plus scoreboarded random checks across four instances
module tb_full_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic v1 = 0, a1 = 0, b1 = 0, c1 = 0, ov1, d1, bo1;
  logic v8 = 0, c8 = 0, ov8, bo8;
  logic [7:0] a8 = 0, b8 = 0, d8;
  logic v10 = 0, c10 = 0, ovr, bor, ovl, bol;
  logic [9:0] a10 = 0, b10 = 0, dr, dl;

  full_subtractor #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .out_valid(ov1), .diff(d1), .borrow(bo1));
  full_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
    .out_valid(ov8), .diff(d8), .borrow(bo8));
  full_subtractor #(.WIDTH(10), .LOOKAHEAD(0)) ur (.clk(clk), .rst(rst), .in_valid(v10), .a(a10),
    .b(b10), .cin(c10), .out_valid(ovr), .diff(dr), .borrow(bor));
  full_subtractor #(.WIDTH(10), .LOOKAHEAD(1)) ul (.clk(clk), .rst(rst), .in_valid(v10), .a(a10),
    .b(b10), .cin(c10), .out_valid(ovl), .diff(dl), .borrow(bol));

  int total = 0, bad = 0;
  logic [15:0] q1[$], q8[$], qr[$], ql[$];

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  always @(negedge clk) if (ov1) begin
    if (q1.size() == 0) chk("w1 extra result", 16'd1, 16'd0);
    else chk("w1 sb", 16'({bo1, d1}), q1.pop_front());
  end
  always @(negedge clk) if (ov8) begin
    if (q8.size() == 0) chk("w8 extra result", 16'd1, 16'd0);
    else chk("w8 sb", 16'({bo8, d8}), q8.pop_front());
  end
  always @(negedge clk) if (ovr) begin
    if (qr.size() == 0) chk("ripple extra result", 16'd1, 16'd0);
    else chk("ripple sb", 16'({bor, dr}), qr.pop_front());
  end
  always @(negedge clk) if (ovl) begin
    if (ql.size() == 0) chk("la extra result", 16'd1, 16'd0);
    else chk("la sb", 16'({bol, dl}), ql.pop_front());
    chk("la vs ripple", 16'({bol, dl, ovl}), 16'({bor, dr, ovr}));
  end

  typedef struct {int w; logic [7:0] a; logic [7:0] b; logic cin; logic [7:0] d; logic bo;} vec_t;
  vec_t tbl[12];

  task automatic drive10(input logic [9:0] a, input logic [9:0] b, input logic cin);
    logic [10:0] r;
    @(posedge clk) #2;
    v10 = 1; a10 = a; b10 = b; c10 = cin;
    r = {1'b0, a} - {1'b0, b} - 11'(cin);
    qr.push_back(16'(r));
    ql.push_back(16'(r));
  endtask

  initial begin
    tbl[0] = '{1, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0};
    tbl[1] = '{1, 8'd0, 8'd0, 1'b1, 8'd1, 1'b1};
    tbl[2] = '{1, 8'd0, 8'd1, 1'b0, 8'd1, 1'b1};
    tbl[3] = '{1, 8'd0, 8'd1, 1'b1, 8'd0, 1'b1};
    tbl[4] = '{1, 8'd1, 8'd0, 1'b0, 8'd1, 1'b0};
    tbl[5] = '{1, 8'd1, 8'd0, 1'b1, 8'd0, 1'b0};
    tbl[6] = '{1, 8'd1, 8'd1, 1'b0, 8'd0, 1'b0};
    tbl[7] = '{1, 8'd1, 8'd1, 1'b1, 8'd1, 1'b1};
    tbl[8] = '{8, 8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0};
    tbl[9] = '{8, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[10] = '{8, 8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};
    tbl[11] = '{8, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset w1", 16'({ov1, d1, bo1}), 16'd0);
    chk("reset w8", 16'({ov8, d8, bo8}), 16'd0);
    chk("reset ripple", 16'({ovr, dr, bor}), 16'd0);
    chk("reset la", 16'({ovl, dl, bol}), 16'd0);
    @(posedge clk) #2 rst = 0;

    for (int i = 0; i < 12; i++) begin
      @(posedge clk) #2;
      v1 = (tbl[i].w == 1); v8 = (tbl[i].w == 8);
      if (tbl[i].w == 1) begin
        a1 = tbl[i].a[0]; b1 = tbl[i].b[0]; c1 = tbl[i].cin;
        q1.push_back(16'({tbl[i].bo, tbl[i].d[0]}));
      end else begin
        a8 = tbl[i].a; b8 = tbl[i].b; c8 = tbl[i].cin;
        q8.push_back(16'({tbl[i].bo, tbl[i].d}));
      end
    end
    @(posedge clk) #2 v1 = 0; v8 = 0;
    repeat (2) @(posedge clk);

    // Hold: one valid operand, then three idle cycles with changing operands.
    @(posedge clk) #2 v8 = 1; a8 = 8'h00; b8 = 8'h01; c8 = 0;
    q8.push_back(16'h01FF);
    @(posedge clk) #2 v8 = 0; a8 = 8'h33; b8 = 8'h11;
    @(negedge clk) chk("hold pulse", 16'(ov8), 16'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk) #2 a8 = 8'($urandom); b8 = 8'($urandom); c8 = ~c8;
      @(negedge clk) chk("hold idle", 16'({ov8, bo8, d8}), 16'h01FF);
    end

    // Async reset between edges.
    @(posedge clk) #3 rst = 1;
    #1 chk("async reset", 16'({ov8, bo8, d8}), 16'd0);
    @(posedge clk) #2 rst = 0;
    for (int i = 0; i < 3; i++) @(negedge clk) chk("post reset idle", 16'({ov8, bo8, d8}), 16'd0);

    drive10(10'd0, 10'd0, 1'b0);
    drive10(10'd0, 10'd0, 1'b1);
    drive10(10'h3FF, 10'h3FF, 1'b0);
    drive10(10'h3FF, 10'h000, 1'b1);
    drive10(10'h000, 10'h3FF, 1'b1);
    drive10(10'h155, 10'h155, 1'b1);
    drive10(10'h2AA, 10'h2AA, 1'b1);
    for (int i = 0; i < 1000; i++) drive10(10'($urandom), 10'($urandom), 1'($urandom));
    @(posedge clk) #2 v10 = 0;

    for (int i = 0; i < 20 && (q1.size() + q8.size() + qr.size() + ql.size()) != 0; i++)
      @(posedge clk);
    chk("drain", 16'(q1.size() + q8.size() + qr.size() + ql.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
